// File: rtl/mod4_pkg.sv
// Shared definitions for the mod-4 ones-count transmitter and checker.
package mod4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAD  = 2'd2
  } state_t;

  localparam int unsigned PAD_BITS   = 3;
  localparam int unsigned ONES_MAX_W = 64;

  // Count of 1s modulo 4; callers zero-extend narrower words to ONES_MAX_W.
  function automatic logic [1:0] ones_mod4(input logic [ONES_MAX_W-1:0] data);
    logic [1:0] cnt;
    cnt = 2'd0;
    for (int i = 0; i < int'(ONES_MAX_W); i++) begin
      cnt = cnt + 2'(data[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/mod4_pad_tx_popcount.sv
// Combinational ones-count modulo 4 of a DATA_W-bit word (DATA_W <= 64).
module popcount_mod4 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  output logic [1:0]        ones_c
);
  import mod4_pkg::*;

  // Zero-extension leaves the count unchanged.
  assign ones_c = ones_mod4(ONES_MAX_W'(data));

endmodule

// File: rtl/mod4_pad_tx.sv
// Serial transmitter: payload MSB-first, then a 3-bit trailer of k ones and
// (3-k) zeros so every frame carries a multiple of four 1s.
module mod4_pad_tx #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_last,
  output logic              busy
);
  import mod4_pkg::*;

  localparam int unsigned CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [1:0]       PAD_LAST = 2'(PAD_BITS - 1);

  state_t            state, state_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_d;
  logic [1:0]        pad_cnt, pad_cnt_d;
  logic [1:0]        pad_k, pad_k_d;
  logic [1:0]        pad_nxt;
  logic [1:0]        ones_in;
  logic              tx_bit_d, tx_valid_d, tx_last_d, busy_d;
  logic              accept;

  popcount_mod4 #(.DATA_W(DATA_W)) u_popcount (
    .data   (in_data),
    .ones_c (ones_in)
  );

  // Ready in idle or on the final trailer bit so frames can abut.
  assign in_ready = !rst && ((state == ST_IDLE) ||
                             ((state == ST_PAD) && (pad_cnt == PAD_LAST)));
  assign accept   = in_valid && in_ready;
  assign pad_nxt  = pad_cnt + 2'd1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state, datapath and output decode; an accept overrides the frame end.
  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    bit_cnt_d  = bit_cnt;
    pad_cnt_d  = pad_cnt;
    pad_k_d    = pad_k;
    tx_bit_d   = 1'b0;
    tx_valid_d = 1'b0;
    tx_last_d  = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_DATA: begin
        tx_valid_d = 1'b1;
        if (bit_cnt == BIT_LAST) begin
          state_d   = ST_PAD;
          bit_cnt_d = '0;
          pad_cnt_d = 2'd0;
          tx_bit_d  = (pad_k != 2'd0);
        end else begin
          bit_cnt_d = bit_cnt + CNT_W'(1);
          tx_bit_d  = shreg[DATA_W-1];
          shreg_d   = shreg << 1;
        end
      end
      ST_PAD: begin
        if (pad_cnt == PAD_LAST) begin
          state_d   = ST_IDLE;
          pad_cnt_d = 2'd0;
        end else begin
          pad_cnt_d  = pad_nxt;
          tx_valid_d = 1'b1;
          tx_bit_d   = (pad_nxt < pad_k);
          tx_last_d  = (pad_nxt == PAD_LAST);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        shreg_d   = '0;
        bit_cnt_d = '0;
        pad_cnt_d = 2'd0;
        pad_k_d   = 2'd0;
      end
    endcase
    if (accept) begin
      state_d    = ST_DATA;
      shreg_d    = in_data << 1;
      bit_cnt_d  = '0;
      pad_cnt_d  = 2'd0;
      pad_k_d    = 2'd0 - ones_in;
      tx_bit_d   = in_data[DATA_W-1];
      tx_valid_d = 1'b1;
      tx_last_d  = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      pad_cnt  <= 2'd0;
      pad_k    <= 2'd0;
      tx_bit   <= 1'b0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      shreg    <= shreg_d;
      bit_cnt  <= bit_cnt_d;
      pad_cnt  <= pad_cnt_d;
      pad_k    <= pad_k_d;
      tx_bit   <= tx_bit_d;
      tx_valid <= tx_valid_d;
      tx_last  <= tx_last_d;
      busy     <= busy_d;
    end
  end

endmodule
